// File: rtl/csr_pkg.sv
// Shared CSR definitions for the machine interrupt path: CSR addresses,
// MIE/MIP bit positions, mcause codes, controller state encoding and
// small packing/priority helpers.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MIE = 12'h304;
    localparam logic [11:0] CSR_MIP = 12'h344;

    // Bit positions shared by MIE and MIP
    localparam int MEI_BIT = 11;
    localparam int MTI_BIT = 7;
    localparam int MSI_BIT = 3;

    // mcause values (interrupt flag set in bit 31)
    localparam logic [31:0] CAUSE_MEI  = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_NONE = 32'h0000_0000;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_INTRAP = 2'd2;

    // Place the three pending bits at their architectural MIP positions.
    function automatic logic [31:0] mip_pack(input logic meip,
                                             input logic mtip,
                                             input logic msip);
        logic [31:0] word_v;
        word_v          = 32'h0000_0000;
        word_v[MEI_BIT] = meip;
        word_v[MTI_BIT] = mtip;
        word_v[MSI_BIT] = msip;
        return word_v;
    endfunction

    // Fixed priority MEI > MSI > MTI; returns the cause of the winner.
    function automatic logic [31:0] prio_cause(input logic en_e,
                                               input logic en_s,
                                               input logic en_t);
        logic [31:0] cause_v;
        if (en_e) begin
            cause_v = CAUSE_MEI;
        end else if (en_s) begin
            cause_v = CAUSE_MSI;
        end else if (en_t) begin
            cause_v = CAUSE_MTI;
        end else begin
            cause_v = CAUSE_NONE;
        end
        return cause_v;
    endfunction

endpackage

// File: rtl/mip_int_ctrl_irq_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous level interrupt
// line. Cleared by the synchronous active-low reset.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic irq_in,
    output logic irq_sync_out
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], irq_in};
        end
    end

    assign irq_sync_out = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/mip_int_ctrl.sv
// Machine interrupt controller. Synchronises MEI/MTI/MSI into the read-only
// MIP register, qualifies them with the MIE bits and mstatus.MIE, and raises
// a single prioritised trap request whose mcause stays frozen until the
// pipeline acknowledges it. Further requests are held off until mret.
module mip_int_ctrl
    import csr_pkg::*;
#(
    parameter logic [11:0] MIP         = CSR_MIP,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    input  logic        meie_in,
    input  logic        mtie_in,
    input  logic        msie_in,
    input  logic        mstatus_mie_in,
    input  logic [11:0] csr_addr_in,
    input  logic        trap_ack_in,
    input  logic        mret_in,
    output logic        trap_req_out,
    output logic [31:0] mcause_out,
    output logic        irq_pending_out,
    output logic [31:0] mip_reg_out
);

    // MIP is entirely read-only: a CSR write addressed to MIP has no effect,
    // so the address only marks the register for read decode upstream.
    logic        mip_addr_hit_s;
    assign mip_addr_hit_s = (csr_addr_in == MIP);

    logic        e_sync_s, t_sync_s, s_sync_s;
    logic        meip_r, mtip_r, msip_r;
    logic        en_e_s, en_t_s, en_s_s, any_en_s;
    logic [31:0] win_cause_s;

    logic [1:0]  state_r, state_nx_s;
    logic        trap_req_r, trap_req_nx_s;
    logic [31:0] mcause_r, mcause_nx_s;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .irq_in       (e_irq_in),
        .irq_sync_out (e_sync_s)
    );

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_t (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .irq_in       (t_irq_in),
        .irq_sync_out (t_sync_s)
    );

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .irq_in       (s_irq_in),
        .irq_sync_out (s_sync_s)
    );

    // Capture the synchronised lines as the MIP pending bits.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            meip_r <= 1'b0;
            mtip_r <= 1'b0;
            msip_r <= 1'b0;
        end else begin
            meip_r <= e_sync_s;
            mtip_r <= t_sync_s;
            msip_r <= s_sync_s;
        end
    end

    // Qualify pending bits with their individual enables and pick the winner.
    always_comb begin
        en_e_s      = meip_r & meie_in;
        en_t_s      = mtip_r & mtie_in;
        en_s_s      = msip_r & msie_in;
        any_en_s    = en_e_s | en_t_s | en_s_s;
        win_cause_s = prio_cause(en_e_s, en_s_s, en_t_s);
    end

    // Request FSM: ack beats withdraw in REQ; mcause only changes on entry to REQ.
    always_comb begin
        state_nx_s    = state_r;
        trap_req_nx_s = 1'b0;
        mcause_nx_s   = mcause_r;
        case (state_r)
            ST_IDLE: begin
                if (any_en_s && mstatus_mie_in) begin
                    state_nx_s    = ST_REQ;
                    trap_req_nx_s = 1'b1;
                    mcause_nx_s   = win_cause_s;
                end else begin
                    state_nx_s    = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (trap_ack_in) begin
                    state_nx_s    = ST_INTRAP;
                end else if (!mstatus_mie_in || !any_en_s) begin
                    state_nx_s    = ST_IDLE;
                end else begin
                    state_nx_s    = ST_REQ;
                    trap_req_nx_s = 1'b1;
                end
            end
            ST_INTRAP: begin
                if (mret_in) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_INTRAP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Register FSM state and the trap-facing outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            trap_req_r <= 1'b0;
            mcause_r   <= CAUSE_NONE;
        end else begin
            state_r    <= state_nx_s;
            trap_req_r <= trap_req_nx_s;
            mcause_r   <= mcause_nx_s;
        end
    end

    assign trap_req_out    = trap_req_r;
    assign mcause_out      = mcause_r;
    assign irq_pending_out = any_en_s;
    assign mip_reg_out     = mip_pack(meip_r, mtip_r, msip_r);

endmodule

// File: tb/tb_mip_int_ctrl.sv
// Directed self-checking bench for mip_int_ctrl.
module tb_mip_int_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, e_irq_in, t_irq_in, s_irq_in;
    logic        meie_in, mtie_in, msie_in, mstatus_mie_in;
    logic [11:0] csr_addr_in;
    logic        trap_ack_in, mret_in;
    logic        trap_req_out, irq_pending_out;
    logic [31:0] mcause_out, mip_reg_out;

    int checks = 0;
    int errors = 0;

    mip_int_ctrl dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .e_irq_in        (e_irq_in),
        .t_irq_in        (t_irq_in),
        .s_irq_in        (s_irq_in),
        .meie_in         (meie_in),
        .mtie_in         (mtie_in),
        .msie_in         (msie_in),
        .mstatus_mie_in  (mstatus_mie_in),
        .csr_addr_in     (csr_addr_in),
        .trap_ack_in     (trap_ack_in),
        .mret_in         (mret_in),
        .trap_req_out    (trap_req_out),
        .mcause_out      (mcause_out),
        .irq_pending_out (irq_pending_out),
        .mip_reg_out     (mip_reg_out)
    );

    always #5 clk_in = ~clk_in;

    // Advance n rising edges; inputs are driven and outputs sampled on negedges.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    // Return to a clean IDLE with all lines low and all enables set.
    task automatic cleanup();
        e_irq_in = 1'b0; t_irq_in = 1'b0; s_irq_in = 1'b0;
        trap_ack_in = 1'b0; mret_in = 1'b0;
        meie_in = 1'b1; mtie_in = 1'b1; msie_in = 1'b1; mstatus_mie_in = 1'b1;
        rst_in = 1'b0;
        tick(1);
        rst_in = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        e_irq_in = 1'b1; t_irq_in = 1'b1; s_irq_in = 1'b1;
        meie_in = 1'b1; mtie_in = 1'b1; msie_in = 1'b1; mstatus_mie_in = 1'b1;
        csr_addr_in = 12'h344; trap_ack_in = 1'b0; mret_in = 1'b0;
        tick(4);
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL reset_trap got %0b exp 0", trap_req_out); end
        checks++; if (mcause_out !== 32'h0) begin errors++; $display("FAIL reset_mcause got %h exp 0", mcause_out); end
        checks++; if (mip_reg_out !== 32'h0) begin errors++; $display("FAIL reset_mip got %h exp 0", mip_reg_out); end
        checks++; if (irq_pending_out !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b exp 0", irq_pending_out); end
        cleanup();
    endtask

    task automatic test_ext_latency();
        e_irq_in = 1'b1;
        tick(2);
        checks++; if (mip_reg_out !== 32'h0) begin errors++; $display("FAIL lat_mip_early got %h exp 0", mip_reg_out); end
        tick(1);
        checks++; if (mip_reg_out !== 32'h800) begin errors++; $display("FAIL lat_mip got %h exp 800", mip_reg_out); end
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL lat_trap_early got %0b exp 0", trap_req_out); end
        checks++; if (irq_pending_out !== 1'b1) begin errors++; $display("FAIL lat_pending got %0b exp 1", irq_pending_out); end
        tick(1);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL lat_trap got %0b exp 1", trap_req_out); end
        checks++; if (mcause_out !== 32'h8000000B) begin errors++; $display("FAIL lat_mcause got %h exp 8000000b", mcause_out); end
        cleanup();
    endtask

    task automatic test_priority();
        t_irq_in = 1'b1; s_irq_in = 1'b1;
        tick(4);
        checks++; if (mip_reg_out !== 32'h88) begin errors++; $display("FAIL prio_mip got %h exp 88", mip_reg_out); end
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL prio_trap got %0b exp 1", trap_req_out); end
        checks++; if (mcause_out !== 32'h80000003) begin errors++; $display("FAIL prio_mcause got %h exp 80000003", mcause_out); end
        e_irq_in = 1'b1;
        tick(5);
        checks++; if (mcause_out !== 32'h80000003) begin errors++; $display("FAIL prio_frozen got %h exp 80000003", mcause_out); end
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL prio_trap_held got %0b exp 1", trap_req_out); end
        trap_ack_in = 1'b1;
        tick(1);
        trap_ack_in = 1'b0;
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL prio_ack got %0b exp 0", trap_req_out); end
        mret_in = 1'b1;
        tick(1);
        mret_in = 1'b0;
        tick(1);
        checks++; if (mcause_out !== 32'h8000000B) begin errors++; $display("FAIL prio_mei_next got %h exp 8000000b", mcause_out); end
        cleanup();
    endtask

    task automatic test_enable_mask();
        meie_in = 1'b0;
        e_irq_in = 1'b1;
        tick(5);
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL mask_trap got %0b exp 0", trap_req_out); end
        checks++; if (irq_pending_out !== 1'b0) begin errors++; $display("FAIL mask_pending got %0b exp 0", irq_pending_out); end
        checks++; if (mip_reg_out !== 32'h800) begin errors++; $display("FAIL mask_mip got %h exp 800", mip_reg_out); end
        meie_in = 1'b1;
        #1;
        checks++; if (irq_pending_out !== 1'b1) begin errors++; $display("FAIL mask_pending_on got %0b exp 1", irq_pending_out); end
        tick(1);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL mask_trap_on got %0b exp 1", trap_req_out); end
        cleanup();
    endtask

    task automatic test_withdraw();
        t_irq_in = 1'b1;
        tick(4);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL wd_trap got %0b exp 1", trap_req_out); end
        mstatus_mie_in = 1'b0;
        tick(1);
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL wd_drop got %0b exp 0", trap_req_out); end
        checks++; if (mcause_out !== 32'h80000007) begin errors++; $display("FAIL wd_mcause got %h exp 80000007", mcause_out); end
        mstatus_mie_in = 1'b1;
        tick(1);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL wd_idle_rereq got %0b exp 1", trap_req_out); end
        mstatus_mie_in = 1'b0; trap_ack_in = 1'b1;
        tick(1);
        mstatus_mie_in = 1'b1; trap_ack_in = 1'b0;
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL wd_ack_drop got %0b exp 0", trap_req_out); end
        tick(2);
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL wd_ack_wins got %0b exp 0", trap_req_out); end
        mret_in = 1'b1;
        tick(1);
        mret_in = 1'b0;
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL wd_mret_edge got %0b exp 0", trap_req_out); end
        tick(1);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL wd_mret_rereq got %0b exp 1", trap_req_out); end
        cleanup();
    endtask

    task automatic test_mret();
        t_irq_in = 1'b1;
        tick(4);
        trap_ack_in = 1'b1;
        tick(1);
        trap_ack_in = 1'b0;
        tick(5);
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL mret_intrap got %0b exp 0", trap_req_out); end
        trap_ack_in = 1'b1;
        tick(1);
        trap_ack_in = 1'b0;
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL mret_stray_ack got %0b exp 0", trap_req_out); end
        mret_in = 1'b1;
        tick(1);
        mret_in = 1'b0;
        tick(1);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL mret_rereq got %0b exp 1", trap_req_out); end
        checks++; if (mcause_out !== 32'h80000007) begin errors++; $display("FAIL mret_mcause got %h exp 80000007", mcause_out); end
        mret_in = 1'b1;
        tick(1);
        mret_in = 1'b0;
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL mret_in_req got %0b exp 1", trap_req_out); end
        cleanup();
    endtask

    task automatic test_reset_mid();
        e_irq_in = 1'b1;
        tick(4);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL rmid_trap got %0b exp 1", trap_req_out); end
        rst_in = 1'b0;
        tick(1);
        rst_in = 1'b1;
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL rmid_trap_clr got %0b exp 0", trap_req_out); end
        checks++; if (mcause_out !== 32'h0) begin errors++; $display("FAIL rmid_mcause got %h exp 0", mcause_out); end
        checks++; if (mip_reg_out !== 32'h0) begin errors++; $display("FAIL rmid_mip got %h exp 0", mip_reg_out); end
        tick(2);
        checks++; if (mip_reg_out !== 32'h0) begin errors++; $display("FAIL rmid_mip_early got %h exp 0", mip_reg_out); end
        tick(1);
        checks++; if (mip_reg_out !== 32'h800) begin errors++; $display("FAIL rmid_mip_back got %h exp 800", mip_reg_out); end
        checks++; if (trap_req_out !== 1'b0) begin errors++; $display("FAIL rmid_trap_early got %0b exp 0", trap_req_out); end
        tick(1);
        checks++; if (trap_req_out !== 1'b1) begin errors++; $display("FAIL rmid_rereq got %0b exp 1", trap_req_out); end
        checks++; if (mcause_out !== 32'h8000000B) begin errors++; $display("FAIL rmid_mcause_back got %h exp 8000000b", mcause_out); end
        cleanup();
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_ext_latency();
        test_priority();
        test_enable_mask();
        test_withdraw();
        test_mret();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
